shift_exec_stage: RTL and testbench

- Two-stage pipelined shift execute unit; sits between operand read (register file) and writeback.
- Captures shift requests over valid/ready, computes LSL/LSR/ASR/ROR internally, returns registered result plus destination register tag for writeback.
- Full throughput of one op per cycle with backpressure and no bubbles.

---
 rtl/shift_exec_stage.sv | 199 +++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
//
// Two-stage pipelined shift execute unit placed between operand read and
// writeback. It accepts one request per cycle over a valid/ready handshake.
// It computes LSL/LSR/ASR/ROR and presents a registered result together with
// the destination register tag.
//
//   S1 : request register (operand, amount, type, tag)
//   S2 : result register  (shifted result, tag, zero flag [, carry])
//
// Optional feature macro: SHIFT_EXEC_CARRY_EN
//   When defined, adds output out_carry, the last bit shifted out. It is
//   registered with the result and is 0 for amt=0.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   request valid
//   in_ready    out  stage can accept a request (combinational from out_ready)
//   in_data     in   operand [DATA_W]
//   in_amt      in   shift amount [AMT_W]
//   in_type     in   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_rd       in   destination tag [RD_W]
//   out_valid   out  result valid
//   out_ready   in   writeback accepts result
//   out_result  out  shifted result [DATA_W]
//   out_rd      out  destination tag of result [RD_W]
//   out_zero    out  out_result == 0
//   out_carry   out  last bit shifted out (SHIFT_EXEC_CARRY_EN only)
//   busy        out  either pipeline stage holds a valid op
//   op_count    out  completed output handshakes, wrapping [CNT_W]
// -----------------------------------------------------------------------------
module shift_exec_stage #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        in_type,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_zero,
`ifdef SHIFT_EXEC_CARRY_EN
    output logic              out_carry,
`endif
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_t;

    // S1 request register
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [AMT_W-1:0]  r_s1_amt;
    shift_type_t       r_s1_type;
    logic [RD_W-1:0]   r_s1_rd;

    // S2 result register
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_result;
    logic [RD_W-1:0]   r_s2_rd;
    logic              r_s2_zero;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_s2_accept;
    logic              w_in_fire;
    logic              w_s1_to_s2;
    logic              w_out_fire;
    logic [DATA_W-1:0] w_shift_res;

    // The next stage frees up as soon as its current result is being taken,
    // so in_ready depends combinationally on out_ready only.
    assign w_s2_accept = !r_s2_valid || out_ready;
    assign in_ready    = !r_s1_valid || w_s2_accept;
    assign w_in_fire   = in_valid && in_ready;
    assign w_s1_to_s2  = r_s1_valid && w_s2_accept;
    assign w_out_fire  = r_s2_valid && out_ready;

    // Rotate as two opposing shifts: for amt=0 the left shift by DATA_W
    // yields zero, so the operand passes through unchanged.
    always_comb begin
        w_shift_res = r_s1_data;
        unique case (r_s1_type)
            SH_LSL: w_shift_res = r_s1_data << r_s1_amt;
            SH_LSR: w_shift_res = r_s1_data >> r_s1_amt;
            SH_ASR: w_shift_res = $signed(r_s1_data) >>> r_s1_amt;
            SH_ROR: w_shift_res = (r_s1_data >> r_s1_amt)
                                | (r_s1_data << (DATA_W - int'(r_s1_amt)));
            default: w_shift_res = r_s1_data;
        endcase
    end

`ifdef SHIFT_EXEC_CARRY_EN
    logic             r_s2_carry;
    logic             w_carry;
    logic [AMT_W-1:0] w_lsl_idx;
    logic [AMT_W-1:0] w_lsr_idx;

    // For amt>=1: LSL drops data[DATA_W-amt] last, LSR/ASR drop data[amt-1].
    // The modular subtraction is in range for every nonzero amount.
    assign w_lsl_idx = AMT_W'(DATA_W) - r_s1_amt;
    assign w_lsr_idx = r_s1_amt - AMT_W'(1);

    always_comb begin
        w_carry = 1'b0;
        if (r_s1_amt != '0) begin
            unique case (r_s1_type)
                SH_LSL:         w_carry = r_s1_data[w_lsl_idx];
                SH_LSR, SH_ASR: w_carry = r_s1_data[w_lsr_idx];
                SH_ROR:         w_carry = w_shift_res[DATA_W-1];
                default:        w_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_carry <= 1'b0;
        end else if (w_s1_to_s2) begin
            r_s2_carry <= w_carry;
        end
    end

    assign out_carry = r_s2_carry;
`endif

    // S1: load on input handshake, otherwise empty when its op moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_amt   <= '0;
            r_s1_type  <= SH_LSL;
            r_s1_rd    <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_amt   <= in_amt;
                r_s1_type  <= shift_type_t'(in_type);
                r_s1_rd    <= in_rd;
            end else if (w_s1_to_s2) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // S2: result fields change only on a transfer from S1. This keeps them
    // stable while the writeback side stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_rd     <= '0;
            r_s2_zero   <= 1'b0;
        end else begin
            if (w_s1_to_s2) begin
                r_s2_valid  <= 1'b1;
                r_s2_result <= w_shift_res;
                r_s2_rd     <= r_s1_rd;
                r_s2_zero   <= (w_shift_res == '0);
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_out_fire) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_rd     = r_s2_rd;
    assign out_zero   = r_s2_zero;
    assign busy       = r_s1_valid || r_s2_valid;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_type;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_zero;
`ifdef SHIFT_EXEC_CARRY_EN
    logic        out_carry;
`endif
    logic        busy;
    logic [3:0]  op_count;

    int          n_cmp;
    int          n_fail;
    logic [3:0]  exp_cnt;

    shift_exec_stage #(
        .DATA_W(32),
        .AMT_W (5),
        .RD_W  (5),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_type   (in_type),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_rd    (out_rd),
        .out_zero  (out_zero),
`ifdef SHIFT_EXEC_CARRY_EN
        .out_carry (out_carry),
`endif
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_type   = '0;
        in_rd     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        n_cmp++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
        n_cmp++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        n_cmp++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        exp_cnt = 4'd0;
        $display("reset released");
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        in_data   = 32'h0000_0001;
        in_amt    = 5'd4;
        in_type   = 2'b00;
        in_rd     = 5'd3;
        in_valid  = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        step;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        step;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 32'h0000_0010) begin n_fail++; $display("FAIL single_result: got %h want 00000010", out_result); end
        n_cmp++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL single_rd: got %0d want 3", out_rd); end
        n_cmp++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL single_zero: got %b want 0", out_zero); end
        $display("single: rd=%0d result=%h", out_rd, out_result);
        step;
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL single_op_count: got %0d want 1", op_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_res [4];
        int          seen;
        int          first_cyc;
        int          last_cyc;
        exp_res[0] = 32'h0000_0F00;
        exp_res[1] = 32'h0800_000F;
        exp_res[2] = 32'hF800_000F;
        exp_res[3] = 32'h0800_000F;
        seen      = 0;
        first_cyc = -1;
        last_cyc  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc < 4) begin
                in_valid = 1'b1;
                in_data  = 32'h8000_00F0;
                in_amt   = 5'd4;
                in_type  = 2'(cyc);
                in_rd    = 5'(10 + cyc);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 4) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready); end
            end
            if (out_valid) begin
                $display("b2b: rd=%0d result=%h", out_rd, out_result);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_cmp++;
                if (seen >= 4) begin
                    n_fail++; $display("FAIL b2b_extra: got %0d outputs want 4", seen + 1);
                end else if (out_result !== exp_res[seen] || out_rd !== 5'(10 + seen)) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got %h/rd%0d want %h/rd%0d", seen, out_result, out_rd, exp_res[seen], 10 + seen);
                end
                seen++;
                exp_cnt = exp_cnt + 4'd1;
            end
            step;
        end
        n_cmp++; if (seen !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", seen); end
        n_cmp++; if (first_cyc !== 2 || last_cyc !== 5) begin n_fail++; $display("FAIL b2b_timing: got %0d..%0d want 2..5", first_cyc, last_cyc); end
        n_cmp++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_op_count: got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_res [3];
        logic [4:0]  exp_rd  [3];
        int          seen;
        logic        took;
        exp_res[0] = 32'h0000_0002; exp_rd[0] = 5'd1;
        exp_res[1] = 32'h0000_0010; exp_rd[1] = 5'd2;
        exp_res[2] = 32'h8000_0000; exp_rd[2] = 5'd4;
        seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0001; in_amt = 5'd1; in_type = 2'b00; in_rd = 5'd1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept0: got %b want 1", in_ready); end
        step;
        in_data = 32'h0000_0100; in_amt = 5'd4; in_type = 2'b01; in_rd = 5'd2;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: got %b want 1", in_ready); end
        step;
        in_data = 32'h0000_0001; in_amt = 5'd1; in_type = 2'b11; in_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0002 || out_rd !== 5'd1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h/rd%0d want v1 00000002/rd1", i, out_valid, out_result, out_rd);
            end
            step;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            took = in_valid && in_ready;
            if (out_valid) begin
                $display("bp: rd=%0d result=%h", out_rd, out_result);
                n_cmp++;
                if (seen >= 3) begin
                    n_fail++; $display("FAIL bp_duplicate: got %0d outputs want 3", seen + 1);
                end else if (out_result !== exp_res[seen] || out_rd !== exp_rd[seen]) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h/rd%0d want %h/rd%0d", seen, out_result, out_rd, exp_res[seen], exp_rd[seen]);
                end
                seen++;
                exp_cnt = exp_cnt + 4'd1;
            end
            step;
            if (took) in_valid = 1'b0;
        end
        n_cmp++; if (seen !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", seen); end
        n_cmp++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL bp_op_count: got %0d want %0d", op_count, exp_cnt); end
    endtask

    // Drives one request with no backpressure and returns what comes out.
    task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t,
                          input logic [4:0] r, output logic [31:0] res, output logic z,
                          output logic c, output logic ok);
        ok = 1'b0; res = '0; z = 1'b0; c = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_amt = a; in_type = t; in_rd = r;
        step;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                ok  = 1'b1;
                res = out_result;
                z   = out_zero;
`ifdef SHIFT_EXEC_CARRY_EN
                c   = out_carry;
`endif
                break;
            end
            step;
        end
        if (ok) begin
            $display("op: type=%0d amt=%0d data=%h rd=%0d result=%h zero=%b", t, a, d, out_rd, res, z);
            step;
            exp_cnt = exp_cnt + 4'd1;
        end
    endtask

    task automatic test_boundary;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        ok;
        run_op(32'hDEAD_BEEF, 5'd0, 2'b11, 5'd5, res, z, c, ok);
        n_cmp++; if (!ok || res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bnd_ror0: got %h ok%b want deadbeef", res, ok); end
        run_op(32'hDEAD_BEEF, 5'd0, 2'b00, 5'd5, res, z, c, ok);
        n_cmp++; if (!ok || res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bnd_lsl0: got %h ok%b want deadbeef", res, ok); end
`ifdef SHIFT_EXEC_CARRY_EN
        n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL bnd_lsl0_carry: got %b want 0", c); end
`endif
        run_op(32'hDEAD_BEEF, 5'd31, 2'b01, 5'd6, res, z, c, ok);
        n_cmp++; if (!ok || res !== 32'h0000_0001) begin n_fail++; $display("FAIL bnd_lsr31: got %h ok%b want 00000001", res, ok); end
`ifdef SHIFT_EXEC_CARRY_EN
        n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL bnd_lsr31_carry: got %b want 1", c); end
`endif
        run_op(32'hDEAD_BEEF, 5'd31, 2'b10, 5'd7, res, z, c, ok);
        n_cmp++; if (!ok || res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bnd_asr31: got %h ok%b want ffffffff", res, ok); end
        run_op(32'h8000_0000, 5'd1, 2'b00, 5'd8, res, z, c, ok);
        n_cmp++; if (!ok || res !== 32'h0000_0000) begin n_fail++; $display("FAIL bnd_lsl_out: got %h ok%b want 00000000", res, ok); end
        n_cmp++; if (z !== 1'b1) begin n_fail++; $display("FAIL bnd_zero: got %b want 1", z); end
`ifdef SHIFT_EXEC_CARRY_EN
        n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL bnd_lsl_carry: got %b want 1", c); end
`endif
        n_cmp++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL bnd_op_count: got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00FF; in_amt = 5'd4; in_type = 2'b00; in_rd = 5'd9;
        step;
        in_rd = 5'd10;
        step;
        in_rd = 5'd11;
        #1;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstm_full: got busy%b v%b rdy%b want busy1 v1 rdy0", busy, out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_async_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 32'h0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL rstm_async_data: got %h/rd%0d want 0/rd0", out_result, out_rd); end
        n_cmp++; if (busy !== 1'b0 || op_count !== 4'd0) begin n_fail++; $display("FAIL rstm_async_state: got busy%b cnt%0d want busy0 cnt0", busy, op_count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        step;
        n_cmp++; if (in_ready !== 1'b1 || op_count !== 4'd0) begin n_fail++; $display("FAIL rstm_release: got rdy%b cnt%0d want rdy1 cnt0", in_ready, op_count); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstm_stale[%0d]: got v%b busy%b want v0 busy0", i, out_valid, busy); end
            step;
        end
        $display("reset mid-stream recovered");
    endtask

    task automatic test_counter_wrap;
        int seen;
        seen = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            in_valid = (cyc < 17);
            in_data  = 32'(cyc + 1);
            in_amt   = 5'd0;
            in_type  = 2'b00;
            in_rd    = 5'(cyc);
            #1;
            if (out_valid) begin
                n_cmp++; if (out_result !== 32'(seen + 1)) begin n_fail++; $display("FAIL wrap_result[%0d]: got %h want %h", seen, out_result, seen + 1); end
                $display("wrap: rd=%0d result=%h", out_rd, out_result);
                seen++;
            end
            step;
        end
        n_cmp++; if (seen !== 17) begin n_fail++; $display("FAIL wrap_seen: got %0d want 17", seen); end
        n_cmp++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL wrap_op_count: got %0d want 1", op_count); end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_cnt = 4'd0;
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_boundary;
        test_reset_midstream;
        test_counter_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
